// File: rtl/mc10_ram_arbiter.sv
// mc10_ram_arbiter: time-multiplexes one single-port 8-bit RAM between VDG, CPU and an
// optional expansion DMA requester (enabled by defining EXP_DMA_EN). IDLE -> ACCESS -> DATA.
module mc10_ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int CPU_MAX_WAIT = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vdg_req,
    input  logic [ADDR_W-1:0] vdg_addr,
    output logic [7:0]        vdg_dout,
    output logic              vdg_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
`ifdef EXP_DMA_EN
    input  logic              exp_req,
    input  logic              exp_we,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [7:0]        exp_din,
    output logic [7:0]        exp_dout,
    output logic              exp_ack,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_q
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DATA} state_t;
    typedef enum logic [1:0] {G_NONE, G_VDG, G_CPU, G_EXP} grant_t;

    localparam logic [2:0] MAX_WAIT = 3'(CPU_MAX_WAIT);

    state_t            state_q;
    grant_t            grant_q, grant_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] ram_addr_q, addr_d;
    logic [7:0]        ram_din_q, din_d;
    logic              ram_we_q, we_d;
    logic [7:0]        vdg_dout_q, cpu_dout_q;
    logic              vdg_ack_q, cpu_ack_q;
`ifdef EXP_DMA_EN
    logic [7:0]        exp_dout_q;
    logic              exp_ack_q;
`endif

    // Arbitration: the CPU overrides the VDG once it has watched MAX_WAIT VDG grants go by.
    always_comb begin
        grant_d = G_NONE;
        addr_d  = ram_addr_q;
        din_d   = ram_din_q;
        we_d    = 1'b0;
        cnt_d   = cnt_q;
        if (cpu_req && (!vdg_req || cnt_q == MAX_WAIT)) begin
            grant_d = G_CPU;
            addr_d  = cpu_addr;
            din_d   = cpu_din;
            we_d    = cpu_we;
        end else if (vdg_req) begin
            grant_d = G_VDG;
            addr_d  = vdg_addr;
        end
`ifdef EXP_DMA_EN
        else if (exp_req) begin
            grant_d = G_EXP;
            addr_d  = exp_addr;
            din_d   = exp_din;
            we_d    = exp_we;
        end
`endif
        if (!cpu_req || grant_d == G_CPU) begin
            cnt_d = 3'd0;
        end else if (grant_d == G_VDG && cnt_q != MAX_WAIT) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= G_NONE;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            vdg_dout_q <= '0;
            cpu_dout_q <= '0;
            vdg_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
`ifdef EXP_DMA_EN
            exp_dout_q <= '0;
            exp_ack_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q    <= cnt_d;
                    ram_we_q <= we_d;
                    if (grant_d != G_NONE) begin
                        state_q    <= S_ACCESS;
                        grant_q    <= grant_d;
                        wr_q       <= we_d;
                        ram_addr_q <= addr_d;
                        ram_din_q  <= din_d;
                    end
                end
                S_ACCESS: begin
                    ram_we_q  <= 1'b0;
                    state_q   <= S_DATA;
                    vdg_ack_q <= (grant_q == G_VDG);
                    cpu_ack_q <= (grant_q == G_CPU);
`ifdef EXP_DMA_EN
                    exp_ack_q <= (grant_q == G_EXP);
`endif
                end
                S_DATA: begin
                    state_q   <= S_IDLE;
                    vdg_ack_q <= 1'b0;
                    cpu_ack_q <= 1'b0;
`ifdef EXP_DMA_EN
                    exp_ack_q <= 1'b0;
`endif
                    // ram_q now reflects the address presented during ACCESS.
                    if (!wr_q) begin
                        if (grant_q == G_VDG) vdg_dout_q <= ram_q;
                        if (grant_q == G_CPU) cpu_dout_q <= ram_q;
`ifdef EXP_DMA_EN
                        if (grant_q == G_EXP) exp_dout_q <= ram_q;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign vdg_dout = vdg_dout_q;
    assign vdg_ack  = vdg_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign cpu_ack  = cpu_ack_q;
`ifdef EXP_DMA_EN
    assign exp_dout = exp_dout_q;
    assign exp_ack  = exp_ack_q;
`endif

endmodule
